// File: rtl/design_41.sv
// rtl/design_41.sv - registered W-bit adder with one-cycle start/valid handshake.
// Optional DESIGN_41_CARRY_EN adds a registered carry output.
module design_41 #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y,
`ifdef DESIGN_41_CARRY_EN
    output logic         carry,
`endif
    output logic         valid
);

    logic [W-1:0] y_d, y_q;
    logic         valid_d, valid_q;
`ifdef DESIGN_41_CARRY_EN
    logic [W:0]   sum;
    logic         carry_d, carry_q;
`else
    logic [W-1:0] sum;
`endif

    // Operands only reach the registers through the start mux, so X on a/b
    // while idle never disturbs the held result.
    always_comb begin
`ifdef DESIGN_41_CARRY_EN
        sum     = {1'b0, a} + {1'b0, b};
        carry_d = carry_q;
`else
        sum     = a + b;
`endif
        y_d     = y_q;
        valid_d = start;
        if (start) begin
            y_d = sum[W-1:0];
`ifdef DESIGN_41_CARRY_EN
            carry_d = sum[W];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            valid_q <= 1'b0;
`ifdef DESIGN_41_CARRY_EN
            carry_q <= 1'b0;
`endif
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
`ifdef DESIGN_41_CARRY_EN
            carry_q <= carry_d;
`endif
        end
    end

    assign y     = y_q;
    assign valid = valid_q;
`ifdef DESIGN_41_CARRY_EN
    assign carry = carry_q;
`endif

endmodule

// File: tb/tb_design_41.sv
// tb/tb_design_41.sv - self-checking bench for design_41 (vector table plus scoreboard).
module tb_design_41;

    localparam int W = 10;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         valid;
`ifdef DESIGN_41_CARRY_EN
    logic         carry;
`endif

    design_41 #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .y     (y),
`ifdef DESIGN_41_CARRY_EN
        .carry (carry),
`endif
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] y;
        logic         c;
    } sb_t;

    typedef struct {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ev;
        logic [W-1:0] ey;
        logic         ec;
    } vec_t;

    sb_t          sb_q[$];
    vec_t         vecs[10];
    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] last_y = '0;
    logic         last_c = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive, let the edge happen, then check 1ns later.
    task automatic step(input logic s, input logic [W-1:0] ia, input logic [W-1:0] ib);
        logic [W:0] full;
        sb_t        e;
        start = s;
        a     = ia;
        b     = ib;
        @(posedge clk);
        if (s === 1'b1 && rst_n === 1'b1) begin
            full   = {1'b0, ia} + {1'b0, ib};
            e.y    = full[W-1:0];
            e.c    = full[W];
            sb_q.push_back(e);
            last_y = e.y;
            last_c = e.c;
        end
        #1;
        chk("valid", {31'd0, valid}, {31'd0, (s === 1'b1 && rst_n === 1'b1)});
        if (valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_y", {22'd0, y}, {22'd0, e.y});
`ifdef DESIGN_41_CARRY_EN
                chk("sb_carry", {31'd0, carry}, {31'd0, e.c});
`endif
            end
        end else begin
            chk("hold_y", {22'd0, y}, {22'd0, last_y});
`ifdef DESIGN_41_CARRY_EN
            chk("hold_carry", {31'd0, carry}, {31'd0, last_c});
`endif
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1,   10'd3,   10'd4, 1'b1,    10'd7, 1'b0};
        vecs[1] = '{1'b0, 10'd999, 10'd999, 1'b0,    10'd7, 1'b0};
        vecs[2] = '{1'b1, 10'd1000, 10'd100, 1'b1,  10'd76, 1'b1};
        vecs[3] = '{1'b0,  10'd12,  10'd34, 1'b0,   10'd76, 1'b1};
        vecs[4] = '{1'b1, 10'd1023,  10'd1, 1'b1,    10'd0, 1'b1};
        vecs[5] = '{1'b1,   10'd0,   10'd0, 1'b1,    10'd0, 1'b0};
        vecs[6] = '{1'b1,   10'd1,   10'd2, 1'b1,    10'd3, 1'b0};
        vecs[7] = '{1'b1,  10'd10,  10'd20, 1'b1,   10'd30, 1'b0};
        vecs[8] = '{1'b1, 10'd511, 10'd512, 1'b1, 10'd1023, 1'b0};
        vecs[9] = '{1'b0,   10'd5,   10'd6, 1'b0, 10'd1023, 1'b0};

        rst_n = 1'b0;
        start = 1'b1;
        a     = 10'd5;
        b     = 10'd7;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_valid", {31'd0, valid}, 32'd0);
            chk("rst_y", {22'd0, y}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].s, vecs[i].a, vecs[i].b);
            chk("vec_valid", {31'd0, valid}, {31'd0, vecs[i].ev});
            chk("vec_y", {22'd0, y}, {22'd0, vecs[i].ey});
`ifdef DESIGN_41_CARRY_EN
            chk("vec_carry", {31'd0, carry}, {31'd0, vecs[i].ec});
`endif
        end

        // Undriven operands while idle must not reach the outputs.
        step(1'b0, 'x, 'x);

        // Reset asserted during the valid cycle drops the result at once.
        step(1'b1, 10'd50, 10'd60);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        chk("midrst_y", {22'd0, y}, 32'd0);
        sb_q.delete();
        last_y = '0;
        last_c = 1'b0;
        step(1'b0, 10'd1, 10'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 10'd2, 10'd3);
        step(1'b0, 10'd4, 10'd5);

        for (int i = 0; i < 10; i++) begin
            step(1'b1, W'($urandom_range(0, 1023)), W'($urandom_range(0, 1023)));
            step(1'b0, W'($urandom_range(0, 1023)), W'($urandom_range(0, 1023)));
            step(1'b0, W'($urandom_range(0, 1023)), W'($urandom_range(0, 1023)));
        end

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
